// File: rtl/cache_line_responder.sv
// cache_line_responder: single-outstanding line fill / write-back responder with fixed access latency.
// Define CACHE_RESP_WBUF_EN to add a one-entry posted write buffer with read forwarding.
module cache_line_responder #(
  parameter int LINE_W  = 128,
  parameter int IDX_W   = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [LINE_W-1:0] rsp_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lat_write_q, lat_write_d;
  logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [LINE_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;

  logic [LINE_W-1:0] mem [2**IDX_W];
  logic [IDX_W-1:0]  req_idx_s;
  logic              accept_s;
  logic              fast_ack_s;
  logic              pend_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_widx_s;
  logic [LINE_W-1:0] mem_wdata_s;
  logic [LINE_W-1:0] rd_line_s;
  logic              unused_addr_s;

  assign req_idx_s     = req_addr[IDX_W+3:4];
  assign unused_addr_s = ^{req_addr[31:IDX_W+4], req_addr[3:0]};

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

`ifdef CACHE_RESP_WBUF_EN
  logic              wbuf_valid_q, wbuf_valid_d;
  logic [3:0]        wbuf_cnt_q, wbuf_cnt_d;
  logic [IDX_W-1:0]  wbuf_idx_q, wbuf_idx_d;
  logic [LINE_W-1:0] wbuf_data_q, wbuf_data_d;

  // Writes are only ever accepted into an empty buffer, so every write is posted.
  assign req_ready   = req_ready_q & ~(req_write & wbuf_valid_q);
  assign accept_s    = req_valid & req_ready;
  assign fast_ack_s  = req_write;
  assign pend_s      = wbuf_valid_d;
  assign mem_we_s    = wbuf_valid_q & (wbuf_cnt_q == 4'd0);
  assign mem_widx_s  = wbuf_idx_q;
  assign mem_wdata_s = wbuf_data_q;
  assign rd_line_s   = (wbuf_valid_q && (wbuf_idx_q == lat_idx_q)) ? wbuf_data_q : mem[lat_idx_q];

  // Posted write buffer: load on write accept, count down, clear on commit
  always_comb begin
    wbuf_valid_d = wbuf_valid_q;
    wbuf_cnt_d   = wbuf_cnt_q;
    wbuf_idx_d   = wbuf_idx_q;
    wbuf_data_d  = wbuf_data_q;
    if (accept_s && req_write) begin
      wbuf_valid_d = 1'b1;
      wbuf_cnt_d   = LAT_M1;
      wbuf_idx_d   = req_idx_s;
      wbuf_data_d  = req_wdata;
    end else if (wbuf_valid_q) begin
      if (wbuf_cnt_q == 4'd0) begin
        wbuf_valid_d = 1'b0;
      end else begin
        wbuf_cnt_d = wbuf_cnt_q - 4'd1;
      end
    end else begin
      wbuf_valid_d = 1'b0;
    end
  end

  // Write buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_valid_q <= 1'b0;
      wbuf_cnt_q   <= 4'd0;
      wbuf_idx_q   <= {IDX_W{1'b0}};
      wbuf_data_q  <= {LINE_W{1'b0}};
    end else begin
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_cnt_q   <= wbuf_cnt_d;
      wbuf_idx_q   <= wbuf_idx_d;
      wbuf_data_q  <= wbuf_data_d;
    end
  end
`else
  logic [LINE_W-1:0] lat_wdata_q, lat_wdata_d;

  assign req_ready   = req_ready_q;
  assign accept_s    = req_valid & req_ready_q;
  assign fast_ack_s  = 1'b0;
  assign pend_s      = 1'b0;
  assign mem_we_s    = (state_q == ST_WAIT) & (cnt_q == 4'd0) & lat_write_q;
  assign mem_widx_s  = lat_idx_q;
  assign mem_wdata_s = lat_wdata_q;
  assign rd_line_s   = mem[lat_idx_q];

  // Write data latch for the latency path
  always_comb begin
    if (accept_s) begin
      lat_wdata_d = req_wdata;
    end else begin
      lat_wdata_d = lat_wdata_q;
    end
  end

  // Write data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wdata_q <= {LINE_W{1'b0}};
    end else begin
      lat_wdata_q <= lat_wdata_d;
    end
  end
`endif

  // Request/response sequencing; a posted write waits a single cycle before its ack
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_idx_d   = lat_idx_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_WAIT;
          lat_write_d = req_write;
          lat_idx_d   = req_idx_s;
          cnt_d       = fast_ack_s ? 4'd0 : LAT_M1;
          req_ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = lat_write_q;
          rsp_rdata_d = lat_write_q ? {LINE_W{1'b0}} : rd_line_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE) | pend_s;
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      lat_write_q <= 1'b0;
      lat_idx_q   <= {IDX_W{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= {LINE_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_idx_q   <= lat_idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Line storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_widx_s] <= mem_wdata_s;
    end
  end

endmodule
